multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Parametrised multicycle successor to the single-cycle RV32I control unit: an FSM sequences fetch/decode/execute/memory/writeback over several cycles sharing one ALU and one memory port.
- Adds a memory ready handshake, full branch-condition set, illegal-instruction detection with halt/skip modes, and a retired-instruction counter.
- Sits between the instruction register / flag outputs of the datapath and its mux/enable controls.

Parameters:
- CNT_W, 32, width of the instret counter.
- MEM_HANDSHAKE, 1; 1 = memory states wait for mem_ready, 0 = mem_ready ignored and treated as 1.
- HALT_ON_ILLEGAL, 1; 1 = TRAP is terminal until reset, 0 = TRAP lasts one cycle then returns to FETCH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inst  in  32  latched instruction register contents.
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1<rs2.
- ltu  in  1  unsigned rs1<rs2.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access request.
- dmem_we  out  1  memory write enable.
- adr_src  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_we  out  1  instruction register / oldPC load.
- pc_we  out  1  PC load.
- pc_src  out  1  next PC: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4.
- alu_control  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB.
- sel_ext  out  3  immediate type: 0 I, 1 S, 2 B, 3 J, 4 U.
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- rf_we  out  1  register file write.
- illegal  out  1  high in TRAP.
- state  out  4  current state, debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXR 6, EXI 7, ALUWB 8, BRANCH 9, JAL 10 (also serves JALR), LUI 11, AUIPC 12, TRAP 14.
- Output decoding: Moore-style from state; uses inst fields and flags where noted. Unlisted outputs are 0.
- Reset: while rst_n is low, state = FETCH, instret = 0, and every control output is forced to 0. The first request is issued on the first cycle after deassert. Reset mid-instruction aborts it with no instret change.
- FETCH: mem_req = 1, adr_src = 0, a = PC, b = 4, ADD, pc_src = 0. When ready: ir_we = 1, pc_we = 1, go to DECODE; otherwise hold with ir_we = pc_we = 0.
- DECODE: ALUOut = target.
  - JALR: a = rs1, b = imm I, ADD.
  - Otherwise: a = oldPC, b = imm, ADD, with sel_ext by opcode (B branch, J jal, else I).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXR; 0010011 → EXI; 1100011 → BRANCH; 1101111 or 1100111 → JAL; 0110111 → LUI; 0010111 → AUIPC; any other opcode → TRAP.
- MEMADR: a = rs1, b = imm (I for load, S for store), ADD. Go to MEMRD for a load, MEMWR for a store.
- MEMRD: mem_req = 1, adr_src = 1. Waits for ready, then goes to MEMWB.
- MEMWB: result_src = 01, rf_we = 1, then FETCH.
- MEMWR: mem_req = 1, dmem_we = 1, adr_src = 1. Waits for ready, then FETCH. dmem_we is held for the whole wait.
- EXR: a = rs1, b = rs2. Decode by funct3:
  - 000: ADD, or SUB if funct7 = 0100000.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND.
  - 101: SRL, or SRA if funct7 = 0100000.
  - funct7 other than 0000000/0100000, or 0100000 with funct3 outside 000/101 → TRAP, no writeback.
  - Otherwise → ALUWB.
- EXI: a = rs1, b = imm I. Same funct3 map, except 000 is always ADD and 101 selects by inst[30]. Always goes to ALUWB.
- ALUWB: result_src = 00, rf_we = 1, then FETCH.
- BRANCH: a = rs1, b = rs2, SUB, pc_src = 1.
  - pc_we = 1 by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011 → TRAP, pc_we = 0.
  - Otherwise → FETCH.
- JAL: a = oldPC, b = 4, ADD, result_src = 10, rf_we = 1, pc_we = 1, pc_src = 1, then FETCH. The datapath clears bit 0 for JALR.
- LUI: b = imm U, PASSB, result_src = 10, rf_we = 1, then FETCH.
- AUIPC: a = oldPC, b = imm U, ADD, result_src = 10, rf_we = 1, then FETCH.
- TRAP: illegal = 1, no enables. HALT_ON_ILLEGAL = 1: stays in TRAP. HALT_ON_ILLEGAL = 0: one cycle, then FETCH.
- instret: increments by 1 (mod 2^CNT_W) on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JAL, LUI or AUIPC. It never increments from TRAP.
- Latency (ready = 1): branch 3 cycles; R/I/store/JAL, JALR, LUI, AUIPC 3 or 4 cycles (per state path above); load 5 cycles. Each stall cycle adds 1.

Test Plan:
- Reset deasserted, mem_ready = 1, inst = add x3,x1,x2 (0x002081B3) → states 0,1,6,8,0; alu_control = 0 in EXR; rf_we only in ALUWB; instret = 1.
- lw x5,8(x1) (0x0080A283) with mem_ready low for 2 cycles in MEMRD → MEMRD held 3 cycles with mem_req = 1; MEMWB has result_src = 01; total 7 cycles.
- beq with zero = 1, then bne with zero = 1 → pc_we = 1 / pc_src = 1 in BRANCH for the first, pc_we = 0 for the second; instret increments for both.
- inst = 0x0000007F, HALT_ON_ILLEGAL = 1 → TRAP forever, illegal = 1; rst_n low mid-TRAP → FETCH, instret = 0, outputs 0.
- R-type funct7 = 0100000, funct3 = 100, HALT_ON_ILLEGAL = 0 → TRAP for 1 cycle then FETCH, no rf_we, instret unchanged.
- CNT_W = 4, 16 LUIs → instret wraps to 0; jalr x1,0(x2) → DECODE a = rs1, sel_ext = 0; JAL state has rf_we = pc_we = 1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port, with illegal-instruction trapping.
module multicycle_controller #(
    parameter int CNT_W           = 32,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             dmem_we,
    output logic             adr_src,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic [2:0]       sel_ext,
    output logic [1:0]       result_src,
    output logic             rf_we,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_EXI   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_LUI   = 4'd11,
        S_AUIPC  = 4'd12, S_TRAP   = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_S = 3'd1;
    localparam logic [2:0] EXT_B = 3'd2;
    localparam logic [2:0] EXT_J = 3'd3;
    localparam logic [2:0] EXT_U = 3'd4;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub_sel,
                                          input logic sra_sel);
        logic [3:0] op;
        case (f3)
            3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic r_illegal(input logic [2:0] f3, input logic [6:0] f7);
        return ((f7 != F7_BASE) && (f7 != F7_ALT)) ||
               ((f7 == F7_ALT) && (f3 != 3'b000) && (f3 != 3'b101));
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic l, input logic lu);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b100:  t = l;
            3'b101:  t = ~l;
            3'b110:  t = lu;
            3'b111:  t = ~lu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    state_t           state_r, next_s;
    logic [CNT_W-1:0] instret_r;
    logic             retire_s, fin_s, ready_s;
    logic             mem_req_s, dmem_we_s, adr_src_s, ir_we_s, pc_we_s, pc_src_s;
    logic             rf_we_s, illegal_s;
    logic [1:0]       alu_src_a_s, alu_src_b_s, result_src_s;
    logic [3:0]       alu_control_s;
    logic [2:0]       sel_ext_s;

    logic [6:0] opcode_s, funct7_s;
    logic [2:0] funct3_s;
    logic       unused_s;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];
    assign funct7_s = inst[31:25];
    assign unused_s = ^{inst[24:15], inst[11:7]};
    assign ready_s  = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            instret_r <= '0;
        end else begin
            state_r <= next_s;
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        next_s        = state_r;
        mem_req_s     = 1'b0;
        dmem_we_s     = 1'b0;
        adr_src_s     = 1'b0;
        ir_we_s       = 1'b0;
        pc_we_s       = 1'b0;
        pc_src_s      = 1'b0;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = ALU_ADD;
        sel_ext_s     = EXT_I;
        result_src_s  = 2'b00;
        rf_we_s       = 1'b0;
        illegal_s     = 1'b0;
        fin_s         = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b10;
                if (ready_s) begin
                    ir_we_s = 1'b1;
                    pc_we_s = 1'b1;
                    next_s  = S_DECODE;
                end else begin
                    next_s  = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b_s = 2'b01;
                if (opcode_s == OP_JALR) begin
                    alu_src_a_s = 2'b10;
                    sel_ext_s   = EXT_I;
                end else begin
                    alu_src_a_s = 2'b01;
                    if (opcode_s == OP_BRANCH) begin
                        sel_ext_s = EXT_B;
                    end else if (opcode_s == OP_JAL) begin
                        sel_ext_s = EXT_J;
                    end else begin
                        sel_ext_s = EXT_I;
                    end
                end
                case (opcode_s)
                    OP_LOAD, OP_STORE: next_s = S_MEMADR;
                    OP_RTYPE:          next_s = S_EXR;
                    OP_ITYPE:          next_s = S_EXI;
                    OP_BRANCH:         next_s = S_BRANCH;
                    OP_JAL, OP_JALR:   next_s = S_JAL;
                    OP_LUI:            next_s = S_LUI;
                    OP_AUIPC:          next_s = S_AUIPC;
                    default:           next_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (opcode_s == OP_STORE) begin
                    sel_ext_s = EXT_S;
                    next_s    = S_MEMWR;
                end else begin
                    sel_ext_s = EXT_I;
                    next_s    = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                next_s    = ready_s ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                rf_we_s      = 1'b1;
                fin_s        = 1'b1;
                next_s       = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s = 1'b1;
                dmem_we_s = 1'b1;
                adr_src_s = 1'b1;
                fin_s     = 1'b1;
                next_s    = ready_s ? S_FETCH : S_MEMWR;
            end
            S_EXR: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = alu_op(funct3_s, funct7_s == F7_ALT, funct7_s == F7_ALT);
                next_s        = r_illegal(funct3_s, funct7_s) ? S_TRAP : S_ALUWB;
            end
            S_EXI: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_op(funct3_s, 1'b0, inst[30]);
                next_s        = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we_s = 1'b1;
                fin_s   = 1'b1;
                next_s  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = ALU_SUB;
                pc_src_s      = 1'b1;
                // funct3 010/011 are not branch conditions in RV32I.
                if ((funct3_s == 3'b010) || (funct3_s == 3'b011)) begin
                    next_s = S_TRAP;
                end else begin
                    pc_we_s = branch_taken(funct3_s, zero, lt, ltu);
                    fin_s   = 1'b1;
                    next_s  = S_FETCH;
                end
            end
            S_JAL: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                rf_we_s      = 1'b1;
                pc_we_s      = 1'b1;
                pc_src_s     = 1'b1;
                fin_s        = 1'b1;
                next_s       = S_FETCH;
            end
            S_LUI: begin
                alu_src_b_s   = 2'b01;
                sel_ext_s     = EXT_U;
                alu_control_s = ALU_PASSB;
                result_src_s  = 2'b10;
                rf_we_s       = 1'b1;
                fin_s         = 1'b1;
                next_s        = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b01;
                sel_ext_s    = EXT_U;
                result_src_s = 2'b10;
                rf_we_s      = 1'b1;
                fin_s        = 1'b1;
                next_s       = S_FETCH;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                if (HALT_ON_ILLEGAL) begin
                    next_s = S_TRAP;
                end else begin
                    next_s = S_FETCH;
                end
            end
            default: begin
                next_s = S_TRAP;
            end
        endcase
        retire_s = fin_s & (next_s == S_FETCH);
    end

    // Controls are held inactive for as long as reset is asserted.
    always_comb begin
        if (rst_n) begin
            mem_req     = mem_req_s;
            dmem_we     = dmem_we_s;
            adr_src     = adr_src_s;
            ir_we       = ir_we_s;
            pc_we       = pc_we_s;
            pc_src      = pc_src_s;
            alu_src_a   = alu_src_a_s;
            alu_src_b   = alu_src_b_s;
            alu_control = alu_control_s;
            sel_ext     = sel_ext_s;
            result_src  = result_src_s;
            rf_we       = rf_we_s;
            illegal     = illegal_s;
        end else begin
            mem_req     = 1'b0;
            dmem_we     = 1'b0;
            adr_src     = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_control = 4'd0;
            sel_ext     = 3'd0;
            result_src  = 2'b00;
            rf_we       = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign state   = state_r;
    assign instret = instret_r;

endmodule
